// File: rtl/sound_request_scheduler_if.sv
// Requester-side bundle for sound_request_scheduler: request levels, per-requester
// song lengths and enable in, grant/done/status and player controls out.
interface sound_request_scheduler_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned SEL_W = 2,
  parameter int unsigned LEN_W = 12
);
  logic                   enable;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*LEN_W-1:0] len_ms;
  logic [N_REQ-1:0]       grant;
  logic [N_REQ-1:0]       done;
  logic                   busy;
  logic                   play;
  logic [SEL_W-1:0]       song_sel;

  modport master (
    output enable, req, len_ms,
    input  grant, done, busy, play, song_sel
  );

  modport slave (
    input  enable, req, len_ms,
    output grant, done, busy, play, song_sel
  );
endinterface

// File: rtl/sound_request_scheduler.sv
// Fixed-priority scheduler time-sharing one song player among N_REQ requesters.
// Optional preemption by a higher-priority request is built when SND_PREEMPT_EN is defined.
module sound_request_scheduler #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned LEN_W    = 12,
  parameter int unsigned TICK_DIV = 100_000,
  parameter int unsigned GAP_MS   = 20
) (
  input logic                   clock,
  input logic                   reset,
  sound_request_scheduler_if.slave bus
);

  localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned GapW = (GAP_MS > 1) ? $clog2(GAP_MS) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(TICK_DIV - 1);
  localparam logic [GapW-1:0] GapLast = GapW'((GAP_MS > 0) ? GAP_MS - 1 : 0);

  typedef enum logic [1:0] {StIdle, StPlay, StGap, StSwitch} state_e;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] win_q, win_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [PreW-1:0]  presc_q, presc_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic             busy_q, busy_d;
  logic             play_q, play_d;
  logic [SEL_W-1:0] sel_q, sel_d;

  logic             any_req;
  logic [SEL_W-1:0] pick;
  logic             tick;

  // Lowest set index wins.
  always_comb begin
    pick    = '0;
    any_req = |bus.req;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req[i]) pick = SEL_W'(i);
    end
  end

  assign tick = (presc_q == PreLast);

  function automatic logic [LEN_W-1:0] len_of(input logic [SEL_W-1:0] idx);
    logic [LEN_W-1:0] l;
    l = bus.len_ms[int'(idx) * LEN_W +: LEN_W];
    return (l == '0) ? LEN_W'(1) : l;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    rem_d   = rem_q;
    presc_d = presc_q;
    gap_d   = gap_q;
    grant_d = grant_q;
    done_d  = '0;
    busy_d  = busy_q;
    play_d  = play_q;
    sel_d   = sel_q;

    unique case (state_q)
      StIdle: begin
        if (bus.enable && any_req) begin
          state_d = StPlay;
          win_d   = pick;
          sel_d   = pick;
          rem_d   = len_of(pick);
          presc_d = '0;
          grant_d = onehot(pick);
          play_d  = 1'b1;
          busy_d  = 1'b1;
        end
      end

      StPlay: begin
        presc_d = tick ? '0 : presc_q + PreW'(1);
        if (!bus.req[win_q] || !bus.enable) begin
          // Abort wins over completion: no done pulse.
          state_d = StGap;
          play_d  = 1'b0;
          grant_d = '0;
          presc_d = '0;
          gap_d   = '0;
`ifdef SND_PREEMPT_EN
        end else if (any_req && (pick < win_q)) begin
          // Switch target is latched now; the song starts after one silent cycle.
          state_d = StSwitch;
          win_d   = pick;
          play_d  = 1'b0;
          grant_d = '0;
`endif
        end else if (tick) begin
          if (rem_q == LEN_W'(1)) begin
            state_d = StGap;
            play_d  = 1'b0;
            grant_d = '0;
            done_d  = grant_q;
            presc_d = '0;
            gap_d   = '0;
          end else begin
            rem_d = rem_q - LEN_W'(1);
          end
        end
      end

      StGap: begin
        presc_d = tick ? '0 : presc_q + PreW'(1);
        if (GAP_MS == 0) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end else if (tick) begin
          if (gap_q == GapLast) begin
            state_d = StIdle;
            busy_d  = 1'b0;
          end else begin
            gap_d = gap_q + GapW'(1);
          end
        end
      end

      StSwitch: begin
        state_d = StPlay;
        sel_d   = win_q;
        rem_d   = len_of(win_q);
        presc_d = '0;
        grant_d = onehot(win_q);
        play_d  = 1'b1;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      win_q   <= '0;
      rem_q   <= '0;
      presc_q <= '0;
      gap_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      play_q  <= 1'b0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      rem_q   <= rem_d;
      presc_q <= presc_d;
      gap_q   <= gap_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      play_q  <= play_d;
      sel_q   <= sel_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;
  assign bus.play     = play_q;
  assign bus.song_sel = sel_q;

endmodule

// File: tb/tb_sound_request_scheduler.sv
// Bench for sound_request_scheduler with TICK_DIV=10, GAP_MS=2: cycle-count model plus
// directed scenarios; define SND_PREEMPT_EN to also exercise preemption.
module tb_sound_request_scheduler;
  localparam int N  = 4;
  localparam int SW = 2;
  localparam int LW = 12;
  localparam int TD = 10;
  localparam int GM = 2;
  localparam int GapCyc = (GM * TD > 0) ? GM * TD : 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sound_request_scheduler_if #(.N_REQ(N), .SEL_W(SW), .LEN_W(LW)) bus ();

  sound_request_scheduler #(
    .N_REQ(N), .SEL_W(SW), .LEN_W(LW), .TICK_DIV(TD), .GAP_MS(GM)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  // Model: mode 0 idle, 1 play, 2 gap, 3 one silent cycle before a preempting song.
  int m_mode = 0, m_left = 0, m_w = 0, m_tgt = 0;
  logic [N-1:0]  e_grant = '0, e_done = '0;
  logic          e_busy = 1'b0, e_play = 1'b0;
  logic [SW-1:0] e_sel = '0;

  function automatic int lowest(input logic [N-1:0] r);
    for (int i = 0; i < N; i++) if (r[i]) return i;
    return N;
  endfunction

  function automatic int len_cycles(input int i);
    int l;
    l = int'(bus.len_ms[i * LW +: LW]);
    return ((l == 0) ? 1 : l) * TD;
  endfunction

  task automatic m_start(input int w);
    m_w     = w;
    m_mode  = 1;
    m_left  = len_cycles(w);
    e_grant = '0;
    e_grant[w] = 1'b1;
    e_play  = 1'b1;
    e_busy  = 1'b1;
    e_sel   = SW'(w);
  endtask

  task automatic m_gap();
    m_mode  = 2;
    m_left  = GapCyc;
    e_grant = '0;
    e_play  = 1'b0;
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_mode = 0; e_grant = '0; e_done = '0; e_busy = 1'b0; e_play = 1'b0; e_sel = '0;
    end else begin
      e_done = '0;
      case (m_mode)
        0: if (bus.enable && bus.req != '0) m_start(lowest(bus.req));
        1: begin
          if (!bus.req[m_w] || !bus.enable) m_gap();
`ifdef SND_PREEMPT_EN
          else if (lowest(bus.req) < m_w) begin
            m_tgt = lowest(bus.req); m_mode = 3; e_grant = '0; e_play = 1'b0;
          end
`endif
          else begin
            m_left--;
            if (m_left == 0) begin e_done[m_w] = 1'b1; m_gap(); end
          end
        end
        2: begin
          m_left--;
          if (m_left == 0) begin m_mode = 0; e_busy = 1'b0; end
        end
        default: m_start(m_tgt);
      endcase
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clock) begin
    if (!reset) begin
      checks++;
      if (bus.grant !== e_grant || bus.done !== e_done || bus.busy !== e_busy ||
          bus.play !== e_play || bus.song_sel !== e_sel) begin
        errors++;
        $display("FAIL model_cycle t=%0t got g=%b d=%b b=%b p=%b s=%0d want g=%b d=%b b=%b p=%b s=%0d",
                 $time, bus.grant, bus.done, bus.busy, bus.play, bus.song_sel,
                 e_grant, e_done, e_busy, e_play, e_sel);
      end
    end
  end

  int play_cnt = 0, busy_cnt = 0;
  int done_cnt [N];
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.play) play_cnt++;
      if (bus.busy) busy_cnt++;
      for (int i = 0; i < N; i++) if (bus.done[i]) done_cnt[i]++;
    end
  end

  task automatic clear_counts();
    play_cnt = 0;
    busy_cnt = 0;
    for (int i = 0; i < N; i++) done_cnt[i] = 0;
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // kind 0: play high; 1: done[idx]; 2: busy low. Returns just after a negedge.
  task automatic wait_for(input int kind, input int idx);
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < 500 && !hit; n++) begin
      @(negedge clock);
      #1;
      case (kind)
        0:       hit = (bus.play === 1'b1);
        1:       hit = (bus.done[idx] === 1'b1);
        default: hit = (bus.busy === 1'b0);
      endcase
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL wait_timeout kind=%0d idx=%0d got=none want=event", kind, idx);
    end
  endtask

  task automatic set_len(input int i, input int v);
    bus.len_ms[i * LW +: LW] = LW'(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.enable = 1'b1;
    bus.req    = '0;
    bus.len_ms = '0;
    clear_counts();
    repeat (2) @(negedge clock);
    #1;
    chk("reset_outputs", int'({bus.grant, bus.done, bus.busy, bus.play, bus.song_sel}), 0);
    reset = 1'b0;

    // Single request, 3 ms.
    clear_counts();
    set_len(2, 3);
    bus.req = 4'b0100;
    wait_for(0, 0);
    chk("s1_grant", int'(bus.grant), 4);
    chk("s1_sel", int'(bus.song_sel), 2);
    wait_for(1, 2);
    bus.req = '0;
    wait_for(2, 0);
    chk("s1_play_cycles", play_cnt, 30);
    chk("s1_done_pulses", done_cnt[2], 1);
    chk("s1_busy_cycles", busy_cnt, 50);

    // Simultaneous requests resolve by priority.
    clear_counts();
    set_len(1, 2);
    set_len(3, 1);
    bus.req = 4'b1010;
    wait_for(0, 0);
    chk("s2_first_grant", int'(bus.grant), 2);
    wait_for(1, 1);
    bus.req = 4'b1000;
    wait_for(0, 0);
    chk("s2_second_grant", int'(bus.grant), 8);
    chk("s2_second_sel", int'(bus.song_sel), 3);
    wait_for(1, 3);
    bus.req = '0;
    wait_for(2, 0);
    chk("s2_done1", done_cnt[1], 1);
    chk("s2_done3", done_cnt[3], 1);
    chk("s2_play_cycles", play_cnt, 30);

    // Zero length is played as 1 ms.
    clear_counts();
    set_len(0, 0);
    bus.req = 4'b0001;
    wait_for(1, 0);
    bus.req = '0;
    wait_for(2, 0);
    chk("s3_play_cycles", play_cnt, 10);
    chk("s3_done0", done_cnt[0], 1);

    // Requester drops mid-song.
    clear_counts();
    set_len(2, 5);
    bus.req = 4'b0100;
    wait_for(0, 0);
    repeat (7) @(negedge clock);
    #1;
    bus.req = '0;
    wait_for(2, 0);
    chk("s4_play_cycles", play_cnt, 8);
    chk("s4_no_done", done_cnt[2], 0);
    chk("s4_busy_cycles", busy_cnt, 8 + GapCyc);

    // Disabled scheduler grants nothing.
    clear_counts();
    bus.enable = 1'b0;
    bus.req    = 4'b0010;
    repeat (6) @(negedge clock);
    #1;
    chk("s5_disabled_busy", busy_cnt, 0);
    bus.req    = '0;
    bus.enable = 1'b1;
    @(negedge clock);
    #1;

    // Asynchronous reset mid-song, then restart with full length.
    set_len(2, 3);
    bus.req = 4'b0100;
    wait_for(0, 0);
    repeat (5) @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk("s6_reset_outputs", int'({bus.grant, bus.done, bus.busy, bus.play, bus.song_sel}), 0);
    repeat (2) @(negedge clock);
    #1;
    clear_counts();
    reset = 1'b0;
    wait_for(1, 2);
    bus.req = '0;
    wait_for(2, 0);
    chk("s6_restart_play_cycles", play_cnt, 30);
    chk("s6_restart_done", done_cnt[2], 1);

`ifdef SND_PREEMPT_EN
    clear_counts();
    set_len(3, 2);
    set_len(0, 1);
    bus.req = 4'b1000;
    wait_for(0, 0);
    repeat (3) @(negedge clock);
    #1;
    bus.req = 4'b1001;
    @(negedge clock);
    #1;
    chk("p_silent_play", int'(bus.play), 0);
    chk("p_silent_busy", int'(bus.busy), 1);
    @(negedge clock);
    #1;
    chk("p_grant0", int'(bus.grant), 1);
    chk("p_sel0", int'(bus.song_sel), 0);
    wait_for(1, 0);
    bus.req = 4'b1000;
    wait_for(0, 0);
    chk("p_grant3_again", int'(bus.grant), 8);
    wait_for(1, 3);
    bus.req = '0;
    wait_for(2, 0);
    chk("p_done3_once", done_cnt[3], 1);
    chk("p_done0_once", done_cnt[0], 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
